tennis_match: RTL and testbench
===============================

TENNIS_MATCH -- requirements
Module: tennis_match

Interface
REQ-001 SHALL have parameter COURT_W, default 16: LED positions on the court; bit 0 is the right-player end and bit COURT_W-1 is the left-player end.
REQ-002 SHALL have parameter TOG_W, default 22: width of the speed word.
REQ-003 SHALL have parameter SPEED_INIT, default 3531008: speed word value at the start of every point.
REQ-004 SHALL have parameter SPEED_STEP, default 8191: amount subtracted from the speed word on each successful return.
REQ-005 SHALL have parameter SPEED_MIN, default 1000000: floor for the speed word.
REQ-006 SHALL have parameter WIN_SCORE, default 3: points needed to win the match.
REQ-007 SHALL have parameter SCORE_W, default 2: score width; must satisfy WIN_SCORE <= 2^SCORE_W-1.
REQ-008 SHALL have port newclock, input, 1 bit: game tick; all state updates on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-010 SHALL have port right_trigger, input, 1 bit: right player paddle; level sampled at each tick.
REQ-011 SHALL have port left_trigger, input, 1 bit: left player paddle; level sampled at each tick.
REQ-012 SHALL have port ball, output, COURT_W bits: LED pattern.
REQ-013 SHALL have port toggle_val, output, TOG_W bits: speed word sent to the external clock divider.
REQ-014 SHALL have port right_score and port left_score, output, SCORE_W bits each.
REQ-015 SHALL have port state, output, 2 bits: SERVE=0, FLIGHT=1, POINT=2, OVER=3.
REQ-016 SHALL have port rally_cnt, output, 8 bits: returns made in the current point.

Function
REQ-017 SERVE state SHALL hold ball one-hot at the server's end and ignore the non-server trigger.
REQ-018 In SERVE, server trigger = 1 at a tick SHALL move the block to FLIGHT with ball unchanged; the first shift happens on the next tick.
REQ-019 In FLIGHT moving left, ball != MSB SHALL give ball <<= 1 per tick.
REQ-020 In FLIGHT moving left with ball == MSB, left_trigger = 1 SHALL reverse direction, leave ball unchanged, increment rally_cnt (saturating at 255), and set toggle_val = max(toggle_val - SPEED_STEP, SPEED_MIN); the subtraction SHALL be computed without underflow.
REQ-021 In FLIGHT moving left with ball == MSB, left_trigger = 0 SHALL be a miss: right_score + 1, next state POINT.
REQ-022 Rightward flight SHALL mirror REQ-019..021: ball >>= 1, end at bit 0, right_trigger decides the return, and a miss gives left_score + 1.
REQ-023 In FLIGHT, the trigger of the player the ball is moving away from SHALL be ignored.
REQ-024 POINT SHALL last exactly one tick with ball = all ones.
REQ-025 On leaving POINT, if the scorer's score == WIN_SCORE the next state SHALL be OVER; otherwise the next state is SERVE.
REQ-026 On a new serve, the server SHALL be the loser of the point, ball SHALL be placed at the server's end, direction SHALL point away from the server, toggle_val = SPEED_INIT, and rally_cnt = 0.
REQ-027 OVER SHALL give ball = lower COURT_W/2 bits set if right wins, upper COURT_W/2 bits set if left wins; all inputs are ignored until reset.
REQ-028 Scores SHALL never exceed WIN_SCORE; there is no wrap-around.
REQ-029 When both triggers are high, only the trigger relevant to the current state/direction SHALL act.

Reset
REQ-030 reset SHALL act asynchronously and set: ball = 1 (bit 0), state = SERVE, server = right, direction = left, scores = 0, rally_cnt = 0, toggle_val = SPEED_INIT.
REQ-031 Reset asserted mid-flight or in OVER SHALL take effect immediately; with reset held, no tick changes any output.

Configuration
REQ-032 Macro EARLY_SWING_FAULT_EN SHALL control early-swing faults.
- Defined: in FLIGHT, receiver trigger = 1 while the ball is not at the receiver's end is a fault; the point goes to the sender and the next state is POINT.
- Undefined: early receiver presses are ignored.

Verification
REQ-033 Reset, then right_trigger = 1 for 1 tick -> state = 1; ball = 0x0002 on the next tick; ball = 0x8000 on the 15th tick after the serve.
REQ-034 At ball = 0x8000 with left_trigger = 1 -> direction right, rally_cnt = 1, toggle_val = 3522817; ball = 0x4000 on the next tick.
REQ-035 At ball = 0x8000 with left_trigger = 0 -> right_score = 1, state = 2, ball = 0xFFFF for one tick; then state = 0, ball = 0x8000, toggle_val = 3531008, and left must serve.
REQ-036 Right wins 3 points -> state = 3, ball = 0x00FF, held despite trigger activity; reset -> ball = 0x0001, scores = 0.
REQ-037 With the macro defined, left_trigger = 1 at ball = 0x0010 moving left -> right_score + 1, state = 2; without the macro the flight continues unchanged.
REQ-038 Long rally with SPEED_STEP forced large -> toggle_val clamps at SPEED_MIN, no underflow; rally_cnt stops at 255.

Source files
------------

// File: rtl/tennis_match.sv
// Two-player LED tennis: a ball bounces between paddle ends, with scoring, rally speed-up and match end.
// Optional macro EARLY_SWING_FAULT_EN: a receiver pressing before the ball arrives loses the point.
module tennis_match #(
   parameter int COURT_W    = 16,
   parameter int TOG_W      = 22,
   parameter int SPEED_INIT = 3531008,
   parameter int SPEED_STEP = 8191,
   parameter int SPEED_MIN  = 1000000,
   parameter int WIN_SCORE  = 3,
   parameter int SCORE_W    = 2
) (
   input  logic               newclock,
   input  logic               reset,
   input  logic               right_trigger,
   input  logic               left_trigger,
   output logic [COURT_W-1:0] ball,
   output logic [TOG_W-1:0]   toggle_val,
   output logic [SCORE_W-1:0] right_score,
   output logic [SCORE_W-1:0] left_score,
   output logic [1:0]         state,
   output logic [7:0]         rally_cnt
);

   typedef enum logic [1:0] {
      ST_SERVE  = 2'd0,
      ST_FLIGHT = 2'd1,
      ST_POINT  = 2'd2,
      ST_OVER   = 2'd3
   } state_t;

   localparam logic [COURT_W-1:0] BALL_R    = COURT_W'(1);
   localparam logic [COURT_W-1:0] BALL_L    = BALL_R << (COURT_W - 1);
   localparam logic [COURT_W-1:0] ALL_ON    = '1;
   localparam logic [COURT_W-1:0] LOW_HALF  = {{(COURT_W - COURT_W/2){1'b0}}, {(COURT_W/2){1'b1}}};
   localparam logic [COURT_W-1:0] HIGH_HALF = {{(COURT_W/2){1'b1}}, {(COURT_W - COURT_W/2){1'b0}}};
   localparam logic [TOG_W-1:0]   TOG_INIT  = TOG_W'(SPEED_INIT);
   localparam logic [TOG_W-1:0]   TOG_MIN   = TOG_W'(SPEED_MIN);
   localparam logic [TOG_W-1:0]   TOG_STEP  = TOG_W'(SPEED_STEP);
   // Two extra bits so MIN+STEP cannot wrap before the comparison
   localparam logic [TOG_W+1:0]   TOG_THRESH = (TOG_W+2)'(SPEED_MIN) + (TOG_W+2)'(SPEED_STEP);
   localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);

   state_t               state_q, state_d;
   logic [COURT_W-1:0]   ball_q, ball_d;
   logic                 dir_left_q, dir_left_d;
   logic                 server_left_q, server_left_d;
   logic                 scorer_left_q, scorer_left_d;
   logic [TOG_W-1:0]     toggle_q, toggle_d;
   logic [SCORE_W-1:0]   rscore_q, rscore_d;
   logic [SCORE_W-1:0]   lscore_q, lscore_d;
   logic [7:0]           rally_q, rally_d;

   logic                 right_pt, left_pt, returned;
   logic [TOG_W-1:0]     toggle_faster;
   logic [7:0]           rally_inc;
   logic                 scorer_won;

   always_ff @(posedge newclock or posedge reset) begin
      if (reset) begin
         state_q       <= ST_SERVE;
         ball_q        <= BALL_R;
         dir_left_q    <= 1'b1;
         server_left_q <= 1'b0;
         scorer_left_q <= 1'b0;
         toggle_q      <= TOG_INIT;
         rscore_q      <= '0;
         lscore_q      <= '0;
         rally_q       <= '0;
      end else begin
         state_q       <= state_d;
         ball_q        <= ball_d;
         dir_left_q    <= dir_left_d;
         server_left_q <= server_left_d;
         scorer_left_q <= scorer_left_d;
         toggle_q      <= toggle_d;
         rscore_q      <= rscore_d;
         lscore_q      <= lscore_d;
         rally_q       <= rally_d;
      end
   end

   always_comb begin
      toggle_faster = ({2'b00, toggle_q} >= TOG_THRESH) ? (toggle_q - TOG_STEP) : TOG_MIN;
      rally_inc     = (rally_q == 8'hFF) ? rally_q : (rally_q + 8'd1);
      scorer_won    = scorer_left_q ? (lscore_q == WIN) : (rscore_q == WIN);
   end

   always_comb begin
      state_d       = state_q;
      ball_d        = ball_q;
      dir_left_d    = dir_left_q;
      server_left_d = server_left_q;
      scorer_left_d = scorer_left_q;
      toggle_d      = toggle_q;
      rscore_d      = rscore_q;
      lscore_d      = lscore_q;
      rally_d       = rally_q;
      right_pt      = 1'b0;
      left_pt       = 1'b0;
      returned      = 1'b0;

      case (state_q)
         ST_SERVE: begin
            if (server_left_q ? left_trigger : right_trigger)
               state_d = ST_FLIGHT;
         end
         ST_FLIGHT: begin
            if (dir_left_q) begin
               if (ball_q == BALL_L) begin
                  if (left_trigger) returned = 1'b1;
                  else              right_pt = 1'b1;
               end else begin
`ifdef EARLY_SWING_FAULT_EN
                  if (left_trigger) right_pt = 1'b1;
                  else              ball_d   = ball_q << 1;
`else
                  ball_d = ball_q << 1;
`endif
               end
            end else begin
               if (ball_q == BALL_R) begin
                  if (right_trigger) returned = 1'b1;
                  else               left_pt  = 1'b1;
               end else begin
`ifdef EARLY_SWING_FAULT_EN
                  if (right_trigger) left_pt = 1'b1;
                  else               ball_d  = ball_q >> 1;
`else
                  ball_d = ball_q >> 1;
`endif
               end
            end
         end
         ST_POINT: begin
            if (scorer_won) begin
               state_d = ST_OVER;
               ball_d  = scorer_left_q ? HIGH_HALF : LOW_HALF;
            end else begin
               // Loser of the point serves, ball starts at their end heading away
               state_d       = ST_SERVE;
               server_left_d = ~scorer_left_q;
               ball_d        = scorer_left_q ? BALL_R : BALL_L;
               dir_left_d    = scorer_left_q;
               toggle_d      = TOG_INIT;
               rally_d       = '0;
            end
         end
         ST_OVER: begin
         end
      endcase

      if (returned) begin
         dir_left_d = ~dir_left_q;
         rally_d    = rally_inc;
         toggle_d   = toggle_faster;
      end
      if (right_pt || left_pt) begin
         state_d       = ST_POINT;
         ball_d        = ALL_ON;
         scorer_left_d = left_pt;
         if (right_pt && (rscore_q != WIN)) rscore_d = rscore_q + 1'b1;
         if (left_pt && (lscore_q != WIN))  lscore_d = lscore_q + 1'b1;
      end
   end

   assign ball        = ball_q;
   assign toggle_val  = toggle_q;
   assign right_score = rscore_q;
   assign left_score  = lscore_q;
   assign state       = state_q;
   assign rally_cnt   = rally_q;

endmodule

// File: tb/tb_tennis_match.sv
// Directed bench for tennis_match: full-size court for match flow, a small court for the long rally.
module tb_tennis_match;

   logic        newclock;
   logic        reset;
   logic        right_trigger, left_trigger;
   logic [15:0] ball;
   logic [21:0] toggle_val;
   logic [1:0]  right_score, left_score;
   logic [1:0]  state;
   logic [7:0]  rally_cnt;

   logic        r2, l2;
   logic [3:0]  ball2;
   logic [21:0] toggle2;
   logic [1:0]  rscore2, lscore2;
   logic [1:0]  state2;
   logic [7:0]  rally2;

   int tests_run;
   int tests_failed;

   tennis_match dut (
      .newclock      (newclock),
      .reset         (reset),
      .right_trigger (right_trigger),
      .left_trigger  (left_trigger),
      .ball          (ball),
      .toggle_val    (toggle_val),
      .right_score   (right_score),
      .left_score    (left_score),
      .state         (state),
      .rally_cnt     (rally_cnt)
   );

   tennis_match #(
      .COURT_W    (4),
      .SPEED_STEP (1500000)
   ) dut2 (
      .newclock      (newclock),
      .reset         (reset),
      .right_trigger (r2),
      .left_trigger  (l2),
      .ball          (ball2),
      .toggle_val    (toggle2),
      .right_score   (rscore2),
      .left_score    (lscore2),
      .state         (state2),
      .rally_cnt     (rally2)
   );

   initial newclock = 1'b0;
   always #5 newclock = ~newclock;

   task automatic ticks(input int n);
      repeat (n) begin
         @(posedge newclock);
         #1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; right_trigger = 1'b0; left_trigger = 1'b0; r2 = 1'b0; l2 = 1'b0;
      ticks(2);
      tests_run++;
      if (ball !== 16'h0001 || state !== 2'd0 || toggle_val !== 22'd3531008) begin
         tests_failed++;
         $display("FAIL reset_vals: ball=%h state=%0d tog=%0d, want 0001 0 3531008", ball, state, toggle_val);
      end
      tests_run++;
      if (right_score !== 2'd0 || left_score !== 2'd0 || rally_cnt !== 8'd0) begin
         tests_failed++;
         $display("FAIL reset_cnts: rs=%0d ls=%0d rally=%0d, want 0 0 0", right_score, left_score, rally_cnt);
      end
      right_trigger = 1'b1; left_trigger = 1'b1;
      ticks(2);
      tests_run++;
      if (ball !== 16'h0001 || state !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_held: ball=%h state=%0d, want 0001 0", ball, state);
      end
      right_trigger = 1'b0; left_trigger = 1'b0;
      reset = 1'b0;
      ticks(1);
      $display("[TB] reset done");
   endtask

   task automatic test_serve;
      left_trigger = 1'b1;
      ticks(1);
      left_trigger = 1'b0;
      tests_run++;
      if (state !== 2'd0 || ball !== 16'h0001) begin
         tests_failed++;
         $display("FAIL serve_wrong_player: state=%0d ball=%h, want 0 0001", state, ball);
      end
      right_trigger = 1'b1;
      ticks(1);
      right_trigger = 1'b0;
      tests_run++;
      if (state !== 2'd1 || ball !== 16'h0001) begin
         tests_failed++;
         $display("FAIL serve_start: state=%0d ball=%h, want 1 0001", state, ball);
      end
      ticks(1);
      tests_run++;
      if (ball !== 16'h0002) begin
         tests_failed++;
         $display("FAIL serve_shift1: ball=%h, want 0002", ball);
      end
      right_trigger = 1'b1;
      ticks(1);
      right_trigger = 1'b0;
      tests_run++;
      if (ball !== 16'h0004 || state !== 2'd1) begin
         tests_failed++;
         $display("FAIL sender_ignored: ball=%h state=%0d, want 0004 1", ball, state);
      end
      ticks(12);
      tests_run++;
      if (ball !== 16'h4000) begin
         tests_failed++;
         $display("FAIL serve_tick14: ball=%h, want 4000", ball);
      end
      ticks(1);
      tests_run++;
      if (ball !== 16'h8000) begin
         tests_failed++;
         $display("FAIL serve_tick15: ball=%h, want 8000", ball);
      end
      $display("[TB] serve: ball reached %h", ball);
   endtask

   task automatic test_return;
      left_trigger = 1'b1;
      ticks(1);
      left_trigger = 1'b0;
      tests_run++;
      if (ball !== 16'h8000 || rally_cnt !== 8'd1 || toggle_val !== 22'd3522817 || state !== 2'd1) begin
         tests_failed++;
         $display("FAIL left_return: ball=%h rally=%0d tog=%0d state=%0d, want 8000 1 3522817 1",
                  ball, rally_cnt, toggle_val, state);
      end
      ticks(1);
      tests_run++;
      if (ball !== 16'h4000) begin
         tests_failed++;
         $display("FAIL after_return: ball=%h, want 4000", ball);
      end
      ticks(14);
      tests_run++;
      if (ball !== 16'h0001) begin
         tests_failed++;
         $display("FAIL reach_right: ball=%h, want 0001", ball);
      end
      right_trigger = 1'b1; left_trigger = 1'b1;
      ticks(1);
      right_trigger = 1'b0; left_trigger = 1'b0;
      tests_run++;
      if (ball !== 16'h0001 || rally_cnt !== 8'd2 || toggle_val !== 22'd3514626) begin
         tests_failed++;
         $display("FAIL right_return_both: ball=%h rally=%0d tog=%0d, want 0001 2 3514626",
                  ball, rally_cnt, toggle_val);
      end
      ticks(1);
      tests_run++;
      if (ball !== 16'h0002) begin
         tests_failed++;
         $display("FAIL after_right_return: ball=%h, want 0002", ball);
      end
      ticks(14);
      $display("[TB] return: rally=%0d tog=%0d", rally_cnt, toggle_val);
   endtask

   task automatic test_miss;
      ticks(1);
      tests_run++;
      if (right_score !== 2'd1 || left_score !== 2'd0 || state !== 2'd2 || ball !== 16'hFFFF) begin
         tests_failed++;
         $display("FAIL left_miss: rs=%0d ls=%0d state=%0d ball=%h, want 1 0 2 ffff",
                  right_score, left_score, state, ball);
      end
      ticks(1);
      tests_run++;
      if (state !== 2'd0 || ball !== 16'h8000 || toggle_val !== 22'd3531008 || rally_cnt !== 8'd0) begin
         tests_failed++;
         $display("FAIL left_serve_setup: state=%0d ball=%h tog=%0d rally=%0d, want 0 8000 3531008 0",
                  state, ball, toggle_val, rally_cnt);
      end
      right_trigger = 1'b1;
      ticks(1);
      right_trigger = 1'b0;
      tests_run++;
      if (state !== 2'd0) begin
         tests_failed++;
         $display("FAIL right_cannot_serve: state=%0d, want 0", state);
      end
      left_trigger = 1'b1;
      ticks(1);
      left_trigger = 1'b0;
      tests_run++;
      if (state !== 2'd1 || ball !== 16'h8000) begin
         tests_failed++;
         $display("FAIL left_serve: state=%0d ball=%h, want 1 8000", state, ball);
      end
      ticks(1);
      tests_run++;
      if (ball !== 16'h4000) begin
         tests_failed++;
         $display("FAIL left_serve_shift: ball=%h, want 4000", ball);
      end
      ticks(14);
      ticks(1);
      tests_run++;
      if (left_score !== 2'd1 || right_score !== 2'd1 || state !== 2'd2 || ball !== 16'hFFFF) begin
         tests_failed++;
         $display("FAIL right_miss: ls=%0d rs=%0d state=%0d ball=%h, want 1 1 2 ffff",
                  left_score, right_score, state, ball);
      end
      ticks(1);
      tests_run++;
      if (state !== 2'd0 || ball !== 16'h0001 || toggle_val !== 22'd3531008) begin
         tests_failed++;
         $display("FAIL right_serve_setup: state=%0d ball=%h tog=%0d, want 0 0001 3531008",
                  state, ball, toggle_val);
      end
      $display("[TB] miss: score R%0d L%0d", right_score, left_score);
   endtask

   task automatic test_early_swing;
      right_trigger = 1'b1;
      ticks(1);
      right_trigger = 1'b0;
      ticks(4);
      tests_run++;
      if (ball !== 16'h0010) begin
         tests_failed++;
         $display("FAIL early_setup: ball=%h, want 0010", ball);
      end
      left_trigger = 1'b1;
      ticks(1);
      left_trigger = 1'b0;
`ifdef EARLY_SWING_FAULT_EN
      tests_run++;
      if (right_score !== 2'd2 || state !== 2'd2) begin
         tests_failed++;
         $display("FAIL early_fault: rs=%0d state=%0d, want 2 2", right_score, state);
      end
`else
      tests_run++;
      if (ball !== 16'h0020 || state !== 2'd1 || right_score !== 2'd1) begin
         tests_failed++;
         $display("FAIL early_ignored: ball=%h state=%0d rs=%0d, want 0020 1 1", ball, state, right_score);
      end
      ticks(10);
      ticks(1);
      tests_run++;
      if (right_score !== 2'd2 || state !== 2'd2) begin
         tests_failed++;
         $display("FAIL second_left_miss: rs=%0d state=%0d, want 2 2", right_score, state);
      end
`endif
      ticks(1);
      tests_run++;
      if (state !== 2'd0 || ball !== 16'h8000) begin
         tests_failed++;
         $display("FAIL early_next_serve: state=%0d ball=%h, want 0 8000", state, ball);
      end
      $display("[TB] early swing: score R%0d L%0d", right_score, left_score);
   endtask

   task automatic test_over;
      left_trigger = 1'b1;
      ticks(1);
      left_trigger = 1'b0;
      ticks(15);
      right_trigger = 1'b1;
      ticks(1);
      right_trigger = 1'b0;
      ticks(15);
      ticks(1);
      tests_run++;
      if (right_score !== 2'd3 || state !== 2'd2) begin
         tests_failed++;
         $display("FAIL match_point: rs=%0d state=%0d, want 3 2", right_score, state);
      end
      ticks(1);
      tests_run++;
      if (state !== 2'd3 || ball !== 16'h00FF || left_score !== 2'd1) begin
         tests_failed++;
         $display("FAIL over: state=%0d ball=%h ls=%0d, want 3 00ff 1", state, ball, left_score);
      end
      right_trigger = 1'b1; left_trigger = 1'b1;
      ticks(3);
      right_trigger = 1'b0; left_trigger = 1'b0;
      tests_run++;
      if (state !== 2'd3 || ball !== 16'h00FF || right_score !== 2'd3) begin
         tests_failed++;
         $display("FAIL over_hold: state=%0d ball=%h rs=%0d, want 3 00ff 3", state, ball, right_score);
      end
      #2 reset = 1'b1;
      #1;
      tests_run++;
      if (ball !== 16'h0001 || state !== 2'd0 || right_score !== 2'd0 || left_score !== 2'd0) begin
         tests_failed++;
         $display("FAIL over_async_reset: ball=%h state=%0d rs=%0d ls=%0d, want 0001 0 0 0",
                  ball, state, right_score, left_score);
      end
      ticks(1);
      reset = 1'b0;
      $display("[TB] over: reset back to serve");
   endtask

   task automatic test_reset_mid_flight;
      right_trigger = 1'b1;
      ticks(1);
      right_trigger = 1'b0;
      ticks(5);
      tests_run++;
      if (ball !== 16'h0020) begin
         tests_failed++;
         $display("FAIL flight_setup: ball=%h, want 0020", ball);
      end
      #2 reset = 1'b1;
      #1;
      tests_run++;
      if (ball !== 16'h0001 || state !== 2'd0 || toggle_val !== 22'd3531008) begin
         tests_failed++;
         $display("FAIL flight_async_reset: ball=%h state=%0d tog=%0d, want 0001 0 3531008",
                  ball, state, toggle_val);
      end
      right_trigger = 1'b1;
      ticks(2);
      right_trigger = 1'b0;
      tests_run++;
      if (ball !== 16'h0001 || state !== 2'd0) begin
         tests_failed++;
         $display("FAIL flight_reset_held: ball=%h state=%0d, want 0001 0", ball, state);
      end
      reset = 1'b0;
      ticks(1);
      $display("[TB] mid-flight reset done");
   endtask

   task automatic test_long_rally;
      #2 reset = 1'b1;
      ticks(1);
      reset = 1'b0;
      for (int i = 1; i <= 1200; i++) begin
         r2 = (ball2 == 4'h1);
         l2 = (ball2 == 4'h8);
         ticks(1);
         if (i == 5) begin
            tests_run++;
            if (rally2 !== 8'd1 || toggle2 !== 22'd2031008) begin
               tests_failed++;
               $display("FAIL rally_first: rally=%0d tog=%0d, want 1 2031008", rally2, toggle2);
            end
         end
         if (i == 9) begin
            tests_run++;
            if (rally2 !== 8'd2 || toggle2 !== 22'd1000000) begin
               tests_failed++;
               $display("FAIL rally_clamp: rally=%0d tog=%0d, want 2 1000000", rally2, toggle2);
            end
         end
      end
      r2 = 1'b0; l2 = 1'b0;
      tests_run++;
      if (rally2 !== 8'd255 || toggle2 !== 22'd1000000 || state2 !== 2'd1) begin
         tests_failed++;
         $display("FAIL rally_saturate: rally=%0d tog=%0d state=%0d, want 255 1000000 1",
                  rally2, toggle2, state2);
      end
      tests_run++;
      if (rscore2 !== 2'd0 || lscore2 !== 2'd0) begin
         tests_failed++;
         $display("FAIL rally_no_points: rs=%0d ls=%0d, want 0 0", rscore2, lscore2);
      end
      $display("[TB] long rally: rally=%0d tog=%0d", rally2, toggle2);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset = 1'b1; right_trigger = 1'b0; left_trigger = 1'b0; r2 = 1'b0; l2 = 1'b0;
      test_reset();
      test_serve();
      test_return();
      test_miss();
      test_early_swing();
      test_over();
      test_reset_mid_flight();
      test_long_rally();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
